shift_autorange_ctrl: RTL and testbench

//  Auto-ranging controller for the window-select shift connecter. It watches the signed long

---
 rtl/shift_autorange_ctrl_pkg.sv | 22 ++
 rtl/shift_autorange_ctrl_sign_fit_chk.sv | 22 ++
 rtl/shift_autorange_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_shift_autorange_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_autorange_ctrl_pkg.sv
// Shared definitions for the shift auto-range controller: FSM state encoding
// and the largest shift the connecter can be driven to.
package shift_autorange_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    SETTLE = 2'd2
  } ctrl_state_t;

  // Largest usable shift: the window must keep at least one redundant sign
  // bit inside the long word, and the value must fit the shift port.
  function automatic int shift_max(input int l_width, input int s_width,
                                   input int shift_word);
    int by_width;
    int by_port;
    by_width = l_width - s_width - 1;
    by_port  = (1 << shift_word) - 1;
    return (by_width < by_port) ? by_width : by_port;
  endfunction

endpackage

// File: rtl/shift_autorange_ctrl_sign_fit_chk.sv
// Combinational fit check: x fits the S_width window at shift k when every
// bit from S_width+k-1 up to the MSB equals the sign bit.
module sign_fit_chk #(
  parameter int L_width = 32,
  parameter int S_width = 16,
  parameter int K_width = 4
) (
  input  logic [L_width-1:0] x,
  input  logic [K_width-1:0] k,
  output logic               fit
);

  logic [L_width-1:0] diff;

  // Bits that differ from the sign are set; shifting off the window part
  // leaves zero exactly when the upper bits are pure sign extension.
  always_comb begin
    diff = x ^ {L_width{x[L_width-1]}};
    fit  = ((diff >> (32'(S_width - 1) + 32'(k))) == '0);
  end

endmodule

// File: rtl/shift_autorange_ctrl.sv
// Auto-ranging controller for the window-select shift connecter: fast attack
// on overflow, slow decay after HOLD_WIN clean windows, and a manual mode.
module shift_autorange_ctrl
  import shift_autorange_ctrl_pkg::*;
#(
  parameter int L_width    = 32,
  parameter int S_width    = 16,
  parameter int Shift_word = 4,
  parameter int WIN_LOG    = 8,
  parameter int HOLD_WIN   = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  i_clkp,
  input  logic                  i_rstn,
  input  logic                  i_en,
  input  logic                  i_auto,
  input  logic [Shift_word-1:0] i_shift_man,
  input  logic                  i_valid,
  input  logic [L_width-1:0]    i_long,
  output logic [Shift_word-1:0] o_shift,
  output logic                  o_shift_upd,
  output logic                  o_sat,
  output logic [1:0]            o_state
);

  localparam int SMAX_I = shift_max(L_width, S_width, Shift_word);
  localparam logic [Shift_word-1:0] SHIFT_MAX = SMAX_I[Shift_word-1:0];

  localparam int WIN_W  = WIN_LOG + 1;
  localparam int HOLD_W = $clog2(HOLD_WIN + 1);
  localparam int SET_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [WIN_W-1:0]  WIN_FULL = WIN_W'(1) << WIN_LOG;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_WIN);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);

  ctrl_state_t state, state_n;

  logic [Shift_word-1:0] shift_n;
  logic                  upd_n;
  logic                  sat_n;
  logic [WIN_W-1:0]      win_cnt, win_n, win_inc;
  logic                  dirty, dirty_n, dirty_w;
  logic [HOLD_W-1:0]     hold_cnt, hold_n, hold_inc;
  logic [SET_W-1:0]      set_cnt, set_n;

  logic [Shift_word-1:0] shift_dn;
  logic [Shift_word-1:0] man_clip;
  logic                  fit_cur;
  logic                  fit_dn;
  logic                  ovf;
  logic                  room;

  sign_fit_chk #(
    .L_width (L_width),
    .S_width (S_width),
    .K_width (Shift_word)
  ) u_fit_cur (
    .x   (i_long),
    .k   (o_shift),
    .fit (fit_cur)
  );

  sign_fit_chk #(
    .L_width (L_width),
    .S_width (S_width),
    .K_width (Shift_word)
  ) u_fit_dn (
    .x   (i_long),
    .k   (shift_dn),
    .fit (fit_dn)
  );

  assign shift_dn = o_shift - Shift_word'(1);
  assign ovf      = i_valid & ~fit_cur;
  // shift_dn wraps at s==0; the s>0 term keeps that from ever counting as room
  assign room     = (o_shift != '0) & fit_dn;
  assign man_clip = (i_shift_man > SHIFT_MAX) ? SHIFT_MAX : i_shift_man;
  assign win_inc  = win_cnt + WIN_W'(1);
  assign hold_inc = hold_cnt + HOLD_W'(1);
  assign dirty_w  = dirty | ~room;
  assign o_state  = state;

  // Next-state, counter and output-register decode.
  always_comb begin
    state_n = state;
    shift_n = o_shift;
    upd_n   = 1'b0;
    sat_n   = 1'b0;
    win_n   = win_cnt;
    dirty_n = dirty;
    hold_n  = hold_cnt;
    set_n   = set_cnt;

    if (!i_en) begin
      state_n = IDLE;
      win_n   = '0;
      dirty_n = 1'b0;
      hold_n  = '0;
      set_n   = '0;
    end else if (!i_auto) begin
      state_n = IDLE;
      win_n   = '0;
      dirty_n = 1'b0;
      hold_n  = '0;
      set_n   = '0;
      shift_n = man_clip;
      upd_n   = (man_clip != o_shift);
    end else begin
      unique case (state)
        IDLE: begin
          state_n = TRACK;
          win_n   = '0;
          dirty_n = 1'b0;
          hold_n  = '0;
          set_n   = '0;
        end
        TRACK: begin
          if (ovf) begin
            if (o_shift < SHIFT_MAX) begin
              // Overflow beats a completing window: the window is dropped.
              shift_n = o_shift + Shift_word'(1);
              upd_n   = 1'b1;
              state_n = SETTLE;
              win_n   = '0;
              dirty_n = 1'b0;
              hold_n  = '0;
              set_n   = '0;
            end else begin
              sat_n   = 1'b1;
              dirty_n = 1'b1;
            end
          end else if (i_valid) begin
            if (win_inc == WIN_FULL) begin
              win_n   = '0;
              dirty_n = 1'b0;
              if (dirty_w) begin
                hold_n = '0;
              end else if (hold_inc == HOLD_LIM) begin
                shift_n = shift_dn;
                upd_n   = 1'b1;
                hold_n  = '0;
                state_n = SETTLE;
                set_n   = '0;
              end else begin
                hold_n = hold_inc;
              end
            end else begin
              win_n   = win_inc;
              dirty_n = dirty_w;
            end
          end
        end
        SETTLE: begin
          if (set_cnt == SET_LAST) begin
            state_n = TRACK;
            set_n   = '0;
            win_n   = '0;
            dirty_n = 1'b0;
            hold_n  = '0;
          end else begin
            set_n = set_cnt + SET_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn) begin
      state       <= IDLE;
      o_shift     <= SHIFT_MAX;
      o_shift_upd <= 1'b0;
      o_sat       <= 1'b0;
      win_cnt     <= '0;
      dirty       <= 1'b0;
      hold_cnt    <= '0;
      set_cnt     <= '0;
    end else begin
      state       <= state_n;
      o_shift     <= shift_n;
      o_shift_upd <= upd_n;
      o_sat       <= sat_n;
      win_cnt     <= win_n;
      dirty       <= dirty_n;
      hold_cnt    <= hold_n;
      set_cnt     <= set_n;
    end
  end

endmodule

// File: tb/tb_shift_autorange_ctrl.sv
// Directed bench for shift_autorange_ctrl: update pulses are scored against a
// queue of expected shift values (and cycle gaps) pushed when stimulus is set.
module tb_shift_autorange_ctrl;

  typedef struct {
    string      tag;
    logic [3:0] shift;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, en, auto_m, valid, en24;
  logic [3:0]  man, man24;
  logic [31:0] lng;
  logic [3:0]  shift, shift24;
  logic        upd, sat, upd24, sat24;
  logic [1:0]  st, st24;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;
  exp_t q[$];
  exp_t q24[$];

  shift_autorange_ctrl #(
    .L_width(32), .S_width(16), .Shift_word(4),
    .WIN_LOG(2), .HOLD_WIN(2), .SETTLE_CYC(3)
  ) dut (
    .i_clkp(clk), .i_rstn(rstn), .i_en(en), .i_auto(auto_m),
    .i_shift_man(man), .i_valid(valid), .i_long(lng),
    .o_shift(shift), .o_shift_upd(upd), .o_sat(sat), .o_state(st)
  );

  shift_autorange_ctrl #(
    .L_width(24), .S_width(16), .Shift_word(4),
    .WIN_LOG(2), .HOLD_WIN(2), .SETTLE_CYC(3)
  ) dut24 (
    .i_clkp(clk), .i_rstn(rstn), .i_en(en24), .i_auto(1'b0),
    .i_shift_man(man24), .i_valid(1'b0), .i_long(24'h0),
    .o_shift(shift24), .o_shift_upd(upd24), .o_sat(sat24), .o_state(st24)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] s, input int gap);
    exp_t e;
    e.tag = tag; e.shift = s; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic push24(input string tag, input logic [3:0] s);
    exp_t e;
    e.tag = tag; e.shift = s; e.gap = -1;
    q24.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk({tag, "_drain"}, 32'(q.size()), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Score every update pulse of the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (upd === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_upd", 32'(upd), 32'd0);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_shift"}, 32'(shift), 32'(e.shift));
        if (e.gap >= 0) chk({e.tag, "_gap"}, 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  // Score every update pulse of the 24-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (upd24 === 1'b1) begin
      if (q24.size() == 0) begin
        chk("unexpected_upd24", 32'(upd24), 32'd0);
      end else begin
        e = q24.pop_front();
        chk({e.tag, "_shift"}, 32'(shift24), 32'(e.shift));
      end
    end
  end

  initial begin
    rstn = 1'b0; en = 1'b0; auto_m = 1'b1; valid = 1'b0;
    man = 4'd0; lng = 32'h0; en24 = 1'b0; man24 = 4'd0;
    cycles(2);
    rstn = 1'b1;
    cycles(1);

    // reset state with the controller disabled
    chk("rst_shift", 32'(shift), 32'd15);
    chk("rst_upd", 32'(upd), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_state", 32'(st), 32'd0);
    chk("rst_shift24", 32'(shift24), 32'd7);

    // manual mode on the 24-bit instance: clamp to SHIFT_MAX=7
    en24 = 1'b1; man24 = 4'd0; push24("man24_zero", 4'd0);
    cycles(3);
    man24 = 4'd12; push24("man24_clip", 4'd7);
    cycles(3);
    chk("man24_clip_hold", 32'(shift24), 32'd7);
    man24 = 4'd3; push24("man24_three", 4'd3);
    cycles(3);
    chk("man24_three_hold", 32'(shift24), 32'd3);
    chk("man24_drain", 32'(q24.size()), 32'd0);
    chk("man24_state", 32'(st24), 32'd0);
    en24 = 1'b0;

    // slow decay 15 -> 0 on a small constant
    en = 1'b1; auto_m = 1'b1; valid = 1'b1; lng = 32'h0000_0100;
    for (int k = 14; k >= 0; k--) push("decay", 4'(k), (k == 14) ? -1 : 11);
    wait_drain("decay", 300);
    cycles(30);
    chk("decay_floor", 32'(shift), 32'd0);
    chk("decay_state", 32'(st), 32'd1);

    // fast attack from 0: one step per settle period, stable at 4
    lng = 32'h0004_0000;
    push("climb", 4'd1, -1);
    push("climb", 4'd2, 4);
    push("climb", 4'd3, 4);
    push("climb", 4'd4, 4);
    cycles(1);
    chk("climb_latency", 32'(shift), 32'd1);
    wait_drain("climb", 60);
    cycles(40);
    chk("climb_stable", 32'(shift), 32'd4);
    chk("climb_sat", 32'(sat), 32'd0);

    // climb to SHIFT_MAX, then saturate
    lng = 32'h7FFF_FFFF;
    for (int k = 5; k <= 15; k++) push("rise", 4'(k), (k == 5) ? -1 : 4);
    wait_drain("rise", 100);
    valid = 1'b0;
    cycles(5);
    chk("pre_sat", 32'(sat), 32'd0);
    chk("pre_sat_state", 32'(st), 32'd1);
    valid = 1'b1;
    cycles(1);
    valid = 1'b0;
    chk("sat_pulse", 32'(sat), 32'd1);
    chk("sat_shift", 32'(shift), 32'd15);
    chk("sat_no_upd", 32'(upd), 32'd0);
    cycles(1);
    chk("sat_clear", 32'(sat), 32'd0);

    // manual to 0, then negative boundary at s=0
    auto_m = 1'b0; man = 4'd0; push("man_zero", 4'd0, -1);
    cycles(1);
    chk("man_state", 32'(st), 32'd0);
    auto_m = 1'b1; valid = 1'b1; lng = 32'hFFFF_8000;
    cycles(14);
    chk("neg_fit_shift", 32'(shift), 32'd0);
    chk("neg_fit_sat", 32'(sat), 32'd0);
    chk("neg_fit_state", 32'(st), 32'd1);
    lng = 32'hFFFF_7FFF; push("neg_ovf", 4'd1, -1);
    cycles(1);
    valid = 1'b0;
    chk("neg_ovf_latency", 32'(shift), 32'd1);
    chk("neg_ovf_state", 32'(st), 32'd2);

    // abort SETTLE into manual, then reset while settling at s=4
    auto_m = 1'b0; man = 4'd3; push("man_three", 4'd3, -1);
    cycles(1);
    chk("abort_state", 32'(st), 32'd0);
    auto_m = 1'b1; valid = 1'b1; lng = 32'h0004_0000; push("pre_rst", 4'd4, -1);
    cycles(2);
    chk("pre_rst_shift", 32'(shift), 32'd4);
    chk("pre_rst_state", 32'(st), 32'd2);
    rstn = 1'b0; valid = 1'b0;
    cycles(1);
    chk("mid_rst_shift", 32'(shift), 32'd15);
    chk("mid_rst_state", 32'(st), 32'd0);
    chk("mid_rst_upd", 32'(upd), 32'd0);
    chk("mid_rst_sat", 32'(sat), 32'd0);
    rstn = 1'b1;
    cycles(3);

    chk("final_drain", 32'(q.size()), 32'd0);
    chk("final_drain24", 32'(q24.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
